// File: rtl/instr_fetch_pkg.sv
// Shared types for the core's instruction-side logic.
package instr_fetch_pkg;

    // CSR access word shared with the core.
    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } csr_t;

    // Fetch responder sequencing: one state per halfword access.
    typedef enum logic [1:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO
    } fetch_state_t;

    // Word presented to the core while the buffer does not match the pointer.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch responder: assembles a 32-bit instruction from two halfword
// reads of a 16-bit memory and holds it in a one-entry tagged buffer.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter logic [31:0] NOP    = NOP_WORD
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic [31:0]       pointer,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack
);

    fetch_state_t state;
    logic [31:0]  fetch_tag;
    logic [15:0]  staging;
    logic [31:0]  buf_data;
    logic [31:0]  buf_tag;
    logic         buf_ok;

    // Buffer hit is combinational so a repeated pointer costs no cycles.
    always_comb begin
        instr_valid = buf_ok && (buf_tag == pointer);
        instr       = instr_valid ? buf_data : NOP;
    end

    // Fetch sequencer; memory request and address are registered outputs.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            fetch_tag <= '0;
            staging   <= '0;
            buf_data  <= '0;
            buf_tag   <= '0;
            buf_ok    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!instr_valid) begin
                        fetch_tag <= pointer;
                        mem_req   <= 1'b1;
                        // High half sits at 2p; upper pointer bits wrap away.
                        mem_addr  <= {pointer[ADDR_W-2:0], 1'b0};
                        state     <= FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (mem_ack) begin
                        if (pointer != fetch_tag) begin
                            // Core moved on: drop this halfword and restart at the new pointer.
                            fetch_tag <= pointer;
                            mem_addr  <= {pointer[ADDR_W-2:0], 1'b0};
                        end else begin
                            staging  <= mem_rdata;
                            mem_addr <= {fetch_tag[ADDR_W-2:0], 1'b1};
                            state    <= FETCH_LO;
                        end
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) begin
                        // Written even if the pointer moved; the stale tag keeps it invisible.
                        buf_data <= {staging, mem_rdata};
                        buf_tag  <= fetch_tag;
                        buf_ok   <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a wait-state memory model.
module tb_instr_fetch;

    localparam int unsigned ADDR_W = 16;

    logic              clk;
    logic              _reset;
    logic [31:0]       pointer;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    logic [15:0] mem [64];
    int          wait_states;
    int          wcnt;
    logic        ack_force;

    int n_checks;
    int n_pass;

    logic [ADDR_W-1:0] acc_addr [$];
    int                unstable;
    logic              prev_pend;
    logic [ADDR_W-1:0] prev_addr;

    instr_fetch #(
        .ADDR_W (ADDR_W),
        .NOP    (32'h0000_0000)
    ) dut (
        .clk         (clk),
        ._reset      (_reset),
        .pointer     (pointer),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks after wait_states extra cycles per halfword access.
    assign mem_rdata = mem[mem_addr[5:0]];
    assign mem_ack   = (mem_req && (wcnt == wait_states)) || ack_force;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    // Access log and address-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!_reset) begin
            prev_pend = 1'b0;
        end else begin
            if (mem_req && mem_ack) acc_addr.push_back(mem_addr);
            if (prev_pend && mem_req && (mem_addr != prev_addr)) unstable++;
            prev_pend = mem_req && !mem_ack;
            prev_addr = mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!instr_valid && n < limit) begin
            step();
            n++;
        end
    endtask

    int n;
    int base;
    int low_cycles;
    int req_cycles;

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        unstable    = 0;
        prev_pend   = 1'b0;
        prev_addr   = '0;
        wcnt        = 0;
        wait_states = 0;
        ack_force   = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = {i[7:0], ~i[7:0]};
        mem[0] = 16'hABCD;
        mem[1] = 16'h1234;
        pointer = 32'd0;
        _reset  = 1'b0;

        // Reset state
        #2;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        #10;
        _reset = 1'b1;

        // Zero-wait miss of pointer 0: addr 0 then 1, valid in the third cycle
        step();
        check("zw_req_hi", {31'd0, mem_req}, 32'd1);
        check("zw_addr_hi", 32'(mem_addr), 32'd0);
        step();
        check("zw_addr_lo", 32'(mem_addr), 32'd1);
        check("zw_valid_lo", {31'd0, instr_valid}, 32'd0);
        step();
        check("zw_valid", {31'd0, instr_valid}, 32'd1);
        check("zw_instr", instr, 32'hABCD1234);
        check("zw_req_done", {31'd0, mem_req}, 32'd0);

        // Hit: 20 cycles on the same pointer, with a stray ack while idle
        low_cycles = 0;
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            ack_force = (i == 10);
            step();
            if (!instr_valid) low_cycles++;
            if (mem_req) req_cycles++;
        end
        ack_force = 1'b0;
        check("hit_low_cycles", low_cycles, 0);
        check("hit_req_cycles", req_cycles, 0);
        check("hit_total_acc", acc_addr.size(), 2);
        check("hit_instr", instr, 32'hABCD1234);

        // Wait states: 3 extra cycles per halfword -> 1 + 4 + 4 = 9 cycles to valid
        wait_states = 3;
        pointer     = 32'd1;
        #0;
        check("ws_miss_drop", {31'd0, instr_valid}, 32'd0);
        check("ws_miss_nop", instr, 32'h0);
        wait_valid(30, n);
        check("ws_latency", n, 9);
        check("ws_instr", instr, 32'h02FD03FC);
        check("ws_addr_stable", unstable, 0);

        // Pointer 5 -> 9 while the access to halfword 10 is pending
        base    = acc_addr.size();
        pointer = 32'd5;
        step();
        check("pc_first_addr", 32'(mem_addr), 32'd10);
        step();
        pointer = 32'd9;
        wait_valid(40, n);
        check("pc_n_acc", acc_addr.size() - base, 3);
        if (acc_addr.size() - base == 3) begin
            check("pc_acc0", 32'(acc_addr[base]), 32'd10);
            check("pc_acc1", 32'(acc_addr[base + 1]), 32'd18);
            check("pc_acc2", 32'(acc_addr[base + 2]), 32'd19);
        end
        check("pc_instr", instr, 32'h12ED13EC);
        check("pc_addr_stable", unstable, 0);

        // Wrap: 2*0x8001 and 2*0x8001+1 truncate to halfwords 2 and 3
        wait_states = 0;
        pointer     = 32'h0000_8001;
        step();
        check("wrap_addr_hi", 32'(mem_addr), 32'h0002);
        step();
        check("wrap_addr_lo", 32'(mem_addr), 32'h0003);
        step();
        check("wrap_instr", instr, 32'h02FD03FC);

        // Reset asserted mid-cycle during a pending fetch
        wait_states = 3;
        pointer     = 32'd7;
        step();
        check("mr_req_before", {31'd0, mem_req}, 32'd1);
        #3;
        _reset = 1'b0;
        #1;
        check("mr_req", {31'd0, mem_req}, 32'd0);
        check("mr_valid", {31'd0, instr_valid}, 32'd0);
        check("mr_instr", instr, 32'h0);
        step();
        _reset = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
